// File: rtl/alu_sin_rx.sv
// alu_sin_rx: serial receiver/deserializer sitting directly upstream of the ALU core.
// Packets are 11 bits (start 0, type, 8 payload bits MSB first, stop 1), one bit per clk.
// A frame is DATA_PKTS data packets (B then A, MSB byte first) closed by one CTL packet
// carrying {0, op, crc}. The checked bundle is handed over on a valid/ready handshake.
// Optional feature: define ALU_RX_TIMEOUT_EN to drop a partial frame after
// TIMEOUT_CYCLES consecutive idle-high cycles between packets.
module alu_sin_rx #(
  parameter int DATA_PKTS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op,
  output logic        overrun
);

  localparam int               CNT_W    = $clog2(DATA_PKTS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_PKTS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_PKTS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP
  } state_e;

  // CRC-4, polynomial x^4+x+1, init 0, message consumed MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] word);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ word[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Bit-level receiver state
  state_e           state_q, state_d;
  logic             is_ctl_q, is_ctl_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;

  // Frame-level state
  logic [63:0]      opnd_q, opnd_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             ferr_q, ferr_d;

  // Output bundle registers
  logic             valid_q, valid_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             err_data_q, err_data_d;
  logic             err_crc_q, err_crc_d;
  logic             err_op_q, err_op_d;
  logic             overrun_q, overrun_d;

`ifdef ALU_RX_TIMEOUT_EN
  localparam int               IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  // CTL payload fields and the prioritised frame verdict (only used when a CTL stop is accepted)
  logic [2:0] ctl_op;
  logic [3:0] ctl_crc;
  logic       bad_data, bad_crc, bad_op, bad_any;

  // Decode the CTL payload and rank the errors: data/framing, then CRC, then opcode
  always_comb begin
    ctl_op   = shift_q[6:4];
    ctl_crc  = shift_q[3:0];
    bad_data = (pkt_cnt_q != CNT_FULL) || ferr_q;
    bad_crc  = !bad_data && (ctl_crc != crc4({opnd_q, 1'b1, ctl_op}));
    bad_op   = !bad_data && !bad_crc && !(ctl_op inside {3'b000, 3'b001, 3'b100, 3'b101});
    bad_any  = bad_data || bad_crc || bad_op;
  end

  // Next-state logic: packet FSM, frame accumulation and output handshake
  always_comb begin
    // NOTE: every _d is given its hold value first, so no branch can leave a latch behind.
    state_d    = state_q;
    is_ctl_d   = is_ctl_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    opnd_d     = opnd_q;
    pkt_cnt_d  = pkt_cnt_q;
    ferr_d     = ferr_q;
    valid_d    = valid_q && !out_ready;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    err_data_d = err_data_q;
    err_crc_d  = err_crc_q;
    err_op_d   = err_op_q;
    overrun_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!sin) state_d = S_TYPE;
      end
      S_TYPE: begin
        is_ctl_d  = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        shift_d   = {shift_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (!sin) begin
          // Bad stop bit: packet dropped, frame marked; no resync attempt.
          ferr_d = 1'b1;
        end else if (!is_ctl_q) begin
          opnd_d = {opnd_q[55:0], shift_q};
          if (pkt_cnt_q != CNT_SAT) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end else begin
          pkt_cnt_d = '0;
          ferr_d    = 1'b0;
          // A pending bundle that is not leaving this cycle wins; the new one is dropped.
          if (!valid_q || out_ready) begin
            valid_d    = 1'b1;
            op_d       = ctl_op;
            err_data_d = bad_data;
            err_crc_d  = bad_crc;
            err_op_d   = bad_op;
            b_d        = bad_any ? 32'd0 : opnd_q[63:32];
            a_d        = bad_any ? 32'd0 : opnd_q[31:0];
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef ALU_RX_TIMEOUT_EN
    // Abandon a partial frame after a long idle gap between packets.
    idle_cnt_d = '0;
    if ((state_q == S_IDLE) && sin && (pkt_cnt_q != '0)) begin
      if (idle_cnt_q == IDLE_LAST) begin
        pkt_cnt_d = '0;
        ferr_d    = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end
`endif
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_ctl_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      opnd_q     <= 64'd0;
      pkt_cnt_q  <= '0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 3'd0;
      err_data_q <= 1'b0;
      err_crc_q  <= 1'b0;
      err_op_q   <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      is_ctl_q   <= is_ctl_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      opnd_q     <= opnd_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      err_data_q <= err_data_d;
      err_crc_q  <= err_crc_d;
      err_op_q   <= err_op_d;
      overrun_q  <= overrun_d;
`ifdef ALU_RX_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign op        = op_q;
  assign err_data  = err_data_q;
  assign err_crc   = err_crc_q;
  assign err_op    = err_op_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_alu_sin_rx.sv
// Self-checking bench for alu_sin_rx: directed and randomised frames are serialised
// onto sin; a frame-level model (list of accepted bytes, polynomial-division CRC)
// predicts each bundle. Build with ALU_RX_TIMEOUT_EN to exercise the timeout path.
`timescale 1ns/1ps
module tb_alu_sin_rx;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n, sin, out_ready;
  logic        out_valid;
  logic [31:0] A, B;
  logic [2:0]  op;
  logic        err_data, err_crc, err_op, overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ed;
    logic        ec;
    logic        eo;
  } bundle_t;

  // Model state: bytes of the frame accepted so far and the framing-error flag
  logic [7:0] m_bytes[$];
  bit         m_ferr;
  bundle_t    exp_b, held_b;
  logic       v_before;
  logic [31:0] rb, ra;
  logic [2:0]  ro;
  logic [3:0]  rc;

  alu_sin_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .err_data  (err_data),
    .err_crc   (err_crc),
    .err_op    (err_op),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bundle_t dut_bundle();
    return {A, B, op, err_data, err_crc, err_op};
  endfunction

  // CRC as the remainder of (message * x^4) divided by x^4+x+1
  function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                         input logic [2:0] o);
    logic [71:0] r;
    r = {b, a, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r = r ^ (72'h13 << (i - 4));
    return r[3:0];
  endfunction

  function automatic bundle_t model(input logic [2:0] o, input logic [3:0] c);
    bundle_t     e;
    logic [31:0] bb, aa;
    e    = '0;
    e.op = o;
    if (m_bytes.size() != 8 || m_ferr) begin
      e.ed = 1'b1;
    end else begin
      bb = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      aa = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
      if (crc_ref(bb, aa, o) != c)                                     e.ec = 1'b1;
      else if (!(o == 3'b000 || o == 3'b001 || o == 3'b100 || o == 3'b101)) e.eo = 1'b1;
      else begin
        e.a = aa;
        e.b = bb;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    tick();
  endtask

  task automatic send_pkt(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    if (!stop) send_bit(1'b1);  // return line to idle
    if (!t) begin
      if (stop) m_bytes.push_back(d);
      else      m_ferr = 1'b1;
    end
  endtask

  task automatic send_words(input logic [31:0] b, input logic [31:0] a);
    logic [63:0] w;
    w = {b, a};
    for (int i = 0; i < 8; i++) send_pkt(1'b0, w[63-8*i -: 8], 1'b1);
  endtask

  task automatic send_ctl(input logic [2:0] o, input logic [3:0] c, input bit rdy_at_stop);
    logic [7:0] p;
    p = {1'b0, o, c};
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 7; i >= 0; i--) send_bit(p[i]);
    if (rdy_at_stop) out_ready = 1'b1;
    exp_b = model(o, c);
    m_bytes.delete();
    m_ferr   = 1'b0;
    v_before = out_valid;
    send_bit(1'b1);
  endtask

  task automatic frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o,
                       input logic [3:0] c, input bit rdy_at_stop);
    send_words(b, a);
    send_ctl(o, c, rdy_at_stop);
  endtask

  initial begin
    rst_n     = 1'b0;
    sin       = 1'b1;
    out_ready = 1'b1;
    m_ferr    = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 128'({out_valid, A, B, op, err_data, err_crc, err_op, overrun}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Directed good frame: B=2, A=1, ADD; CRC worked out by hand as 4'hC
    frame(32'd2, 32'd1, 3'b100, 4'hC, 1'b0);
    check("t1_valid_latency", 128'(v_before), 128'(0));
    check("t1_valid",         128'(out_valid), 128'(1));
    check("t1_bundle_lit",    128'(dut_bundle()), 128'({32'd1, 32'd2, 3'b100, 3'b000}));
    check("t1_bundle_model",  128'(dut_bundle()), 128'(exp_b));
    check("t1_no_overrun",    128'(overrun), 128'(0));
    tick();
    check("t1_xfer_clears",   128'(out_valid), 128'(0));

    // Same frame, CRC bit 0 inverted
    frame(32'd2, 32'd1, 3'b100, 4'hD, 1'b0);
    check("t2_crc_lit",   128'(dut_bundle()), 128'({32'd0, 32'd0, 3'b100, 3'b010}));
    check("t2_crc_model", 128'(dut_bundle()), 128'(exp_b));
    tick();

    // 7 data packets, then 9 data packets
    for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
    send_ctl(3'b100, 4'h0, 1'b0);
    check("t3_short", 128'(dut_bundle()), 128'({32'd0, 32'd0, 3'b100, 3'b100}));
    tick();
    for (int i = 0; i < 9; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
    send_ctl(3'b001, 4'h0, 1'b0);
    check("t3_long", 128'(dut_bundle()), 128'({32'd0, 32'd0, 3'b001, 3'b100}));
    tick();

    // Illegal opcode with correct CRC
    frame(32'd5, 32'd3, 3'b011, crc_ref(32'd5, 32'd3, 3'b011), 1'b0);
    check("t4_badop_lit",   128'(dut_bundle()), 128'({32'd0, 32'd0, 3'b011, 3'b001}));
    check("t4_badop_model", 128'(dut_bundle()), 128'(exp_b));
    tick();

    // Randomised frames, occasionally with a corrupted CRC
    for (int n = 0; n < 10; n++) begin
      rb = $urandom;
      ra = $urandom;
      ro = 3'($urandom_range(0, 7));
      rc = crc_ref(rb, ra, ro);
      if ($urandom_range(0, 3) == 0) rc = rc ^ 4'(1 << $urandom_range(0, 3));
      frame(rb, ra, ro, rc, 1'b0);
      check($sformatf("t5_rand_valid_%0d", n), 128'(out_valid), 128'(1));
      check($sformatf("t5_rand_bundle_%0d", n), 128'(dut_bundle()), 128'(exp_b));
      tick();
    end

    // Framing error in the middle of an otherwise complete frame
    rb = $urandom;
    ra = $urandom;
    send_words(rb, 32'd0);
    send_pkt(1'b0, 8'hA5, 1'b0);
    send_ctl(3'b000, crc_ref(rb, 32'd0, 3'b000), 1'b0);
    check("t6_framing", 128'(dut_bundle()), 128'({32'd0, 32'd0, 3'b000, 3'b100}));
    tick();

    // Overrun: second frame completes while the first is still held
    out_ready = 1'b0;
    rb = $urandom; ra = $urandom;
    frame(rb, ra, 3'b101, crc_ref(rb, ra, 3'b101), 1'b0);
    held_b = exp_b;
    check("t7_first_valid", 128'(out_valid), 128'(1));
    check("t7_first_bundle", 128'(dut_bundle()), 128'(held_b));
    rb = $urandom; ra = $urandom;
    frame(rb, ra, 3'b000, crc_ref(rb, ra, 3'b000), 1'b0);
    check("t7_overrun_pulse", 128'(overrun), 128'(1));
    check("t7_held_bundle", 128'({out_valid, dut_bundle()}), 128'({1'b1, held_b}));
    tick();
    check("t7_overrun_single", 128'(overrun), 128'(0));
    check("t7_still_held", 128'(dut_bundle()), 128'(held_b));
    out_ready = 1'b1;
    tick();
    check("t7_xfer_clears", 128'(out_valid), 128'(0));

    // Completion in the same cycle as a transfer loads the new bundle
    out_ready = 1'b0;
    rb = $urandom; ra = $urandom;
    frame(rb, ra, 3'b001, crc_ref(rb, ra, 3'b001), 1'b0);
    rb = $urandom; ra = $urandom;
    frame(rb, ra, 3'b100, crc_ref(rb, ra, 3'b100), 1'b1);
    check("t8_same_cycle", 128'({out_valid, overrun, dut_bundle()}), 128'({2'b10, exp_b}));
    tick();
    check("t8_xfer_clears", 128'(out_valid), 128'(0));

    // Reset during the 4th data packet while a bundle is held
    out_ready = 1'b0;
    rb = $urandom; ra = $urandom;
    frame(rb, ra, 3'b100, crc_ref(rb, ra, 3'b100), 1'b0);
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check("t9_reset_async", 128'({out_valid, A, B, op, err_data, err_crc, err_op, overrun}), 128'(0));
    m_bytes.delete();
    m_ferr = 1'b0;
    sin    = 1'b1;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    rb = $urandom; ra = $urandom;
    frame(rb, ra, 3'b101, crc_ref(rb, ra, 3'b101), 1'b0);
    check("t9_after_reset", 128'({out_valid, dut_bundle()}), 128'({1'b1, exp_b}));
    tick();

    // Partial frame followed by a long idle gap, then a full frame
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
    repeat (TIMEOUT) send_bit(1'b1);
`ifdef ALU_RX_TIMEOUT_EN
    m_bytes.delete();
    m_ferr = 1'b0;
`endif
    rb = $urandom; ra = $urandom;
    frame(rb, ra, 3'b000, crc_ref(rb, ra, 3'b000), 1'b0);
    check("t10_idle_gap", 128'({out_valid, dut_bundle()}), 128'({1'b1, exp_b}));
`ifdef ALU_RX_TIMEOUT_EN
    check("t10_err_data", 128'(err_data), 128'(0));
`else
    check("t10_err_data", 128'(err_data), 128'(1));
`endif
    tick();
    check("t10_drained", 128'(out_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sin_rx.md
Name: alu_sin_rx

Overview:
- Serial input receiver/deserializer directly upstream of the ALU core.
- Samples the `sin` line one bit per clock and assembles 8 data packets (B then A, MSB byte first) plus 1 control packet.
- Checks framing, packet count, CRC-4 and opcode.
- Presents one operand/opcode/error bundle per frame to the ALU core over a valid/ready handshake.

Parameters:
- DATA_PKTS, 8, number of data packets expected before the CTL packet.
- TIMEOUT_CYCLES, 64, idle cycles mid-frame before abort (used only with ALU_RX_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial input; idles high.
- out_ready  input  1  ALU core accepts bundle.
- out_valid  output  1  bundle available.
- A  output  32  operand A (signed).
- B  output  32  operand B (signed).
- op  output  3  opcode.
- err_data  output  1  packet-count or framing error.
- err_crc  output  1  CRC mismatch.
- err_op  output  1  illegal opcode.
- overrun  output  1  one-cycle pulse: completed frame dropped.

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk.
- Reset values: all outputs 0; FSM in IDLE; counters and shift registers 0.
- Packet format, 11 bits, one bit per clk:
  - start bit 0;
  - type bit: 0 = DATA, 1 = CTL;
  - 8 payload bits, MSB first;
  - stop bit 1.
- CTL payload is {0, op[2:0], crc[3:0]}.
- Bit FSM:
  - IDLE: sin=0 → TYPE.
  - TYPE: latch type → PAYLOAD, bit counter 0.
  - PAYLOAD: shift 8 bits; counter 7 → STOP.
  - STOP: sin=1 → packet accepted; sin=0 → framing error (sets frame err_data flag). Go to IDLE either way.
- DATA packet accepted:
  - shift byte into a 64-bit operand register;
  - pkt_cnt increments, saturating at DATA_PKTS+1.
- CTL packet accepted → frame complete; result evaluated with this priority:
  1. err_data: pkt_cnt != DATA_PKTS, or a framing error anywhere in the frame.
  2. err_crc: crc != CRC4 over the 68-bit word {B, A, 1'b1, op}. Polynomial x^4+x+1, init 0, MSB first.
  3. err_op: op not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
  4. Otherwise no error.
- Exactly one err_* bit is set when erroneous.
- On any error, A and B are driven 0 and op is still reported.
- Byte order: first 4 data bytes form B[31:24..7:0], next 4 form A.
- Latency: out_valid rises the cycle after the CTL stop bit is sampled.
- Handshake:
  - out_valid and the bundle are held stable until out_valid && out_ready.
  - Transfer clears out_valid next cycle.
  - Reception continues while out_valid is pending.
- Boundary conditions:
  - Frame completes while out_valid=1 and out_ready=0: new bundle discarded, overrun pulses 1 cycle, held bundle unchanged.
  - Completion in the same cycle as a transfer is not overrun: new bundle loads.
  - After frame completion pkt_cnt and the frame error flag clear to 0.
  - rst_n low mid-packet or mid-frame: immediate abort, all state to reset values, partial frame lost.
  - Start bit detected only in IDLE; stop-bit-0 does not resynchronise the frame.

Optional Feature:
- ALU_RX_TIMEOUT_EN defined:
  - an idle counter runs while pkt_cnt>0 in IDLE;
  - after TIMEOUT_CYCLES consecutive idle-high cycles, partial frame state is cleared (pkt_cnt=0, flags 0);
  - no bundle is emitted.
- Undefined: no timeout; a partial frame waits indefinitely and merges with later packets.

Test Plan:
- B=2, A=1, op=100, correct CRC, out_ready=1 → out_valid one cycle after CTL stop; A=1, B=2, op=100, all err 0.
- Same frame with CRC bit 0 inverted → err_crc=1, err_data=0, err_op=0, A=B=0.
- 7 DATA packets then valid CTL → err_data=1 only; 9 DATA packets then CTL → err_data=1 only.
- B=5, A=3, op=011, correct CRC → err_op=1 only, op=011.
- out_ready held 0, two valid frames → first bundle held unchanged, overrun single-cycle pulse at second CTL completion; out_ready=1 → transfer, out_valid=0 next cycle.
- rst_n pulsed low during 4th DATA packet → all outputs 0; next full valid frame decoded correctly.
- With ALU_RX_TIMEOUT_EN: 3 DATA packets, 64 idle cycles, then full valid frame → single correct bundle, no err_data.
